// File: rtl/wb_mem.sv
// wb_mem: Wishbone B4 pipelined single-port 32-bit memory slave with programmable wait states.
// Optional macro WB_MEM_ERR_EN adds wb_err_o and rejects addresses beyond the memory span.
module wb_mem #(
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  output logic        wb_ack_o,
  output logic        wb_stall_o
`ifdef WB_MEM_ERR_EN
  ,
  output logic        wb_err_o
`endif
);

  localparam int unsigned DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [1:0]  ST_IDLE   = 2'd0;
  localparam logic [1:0]  ST_WAIT   = 2'd1;
  localparam logic [1:0]  ST_RESP   = 2'd2;
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

  logic [1:0]            r_state;
  logic [1:0]            w_state_nxt;
  logic [3:0]            r_cnt;
  logic [3:0]            w_cnt_nxt;
  logic [DEPTH_LOG2-1:0] r_idx;
  logic [31:0]           r_dat;
  logic [3:0]            r_sel;
  logic                  r_we;
  logic                  r_err;
  logic                  r_ack;
  logic [31:0]           r_dat_o;
  logic [31:0]           r_mem [DEPTH];

  logic                  w_req;
  logic                  w_accept;
  logic                  w_adr_err;
  logic                  w_go_resp;
  logic                  w_wr_en;
  logic [DEPTH_LOG2-1:0] w_cur_idx;
  logic [31:0]           w_cur_dat;
  logic [3:0]            w_cur_sel;
  logic                  w_cur_we;
  logic                  w_cur_err;
  logic [31:0]           w_lane_mask;
  logic [31:0]           w_rd_word;
  logic                  w_unused_adr;

  assign w_req    = wb_cyc_i & wb_stb_i;
  assign w_accept = (r_state == ST_IDLE) & w_req;

`ifdef WB_MEM_ERR_EN
  assign w_adr_err = |wb_adr_i[31:DEPTH_LOG2+2];
`else
  assign w_adr_err = 1'b0;
`endif

  // Byte offset and (without error checking) the high bits never select storage.
  assign w_unused_adr = ^{wb_adr_i[31:DEPTH_LOG2+2], wb_adr_i[1:0]};

  // With zero wait states RESP is entered on the accepting edge, so use the live bus fields.
  assign w_cur_idx = w_accept ? wb_adr_i[DEPTH_LOG2+1:2] : r_idx;
  assign w_cur_dat = w_accept ? wb_dat_i : r_dat;
  assign w_cur_sel = w_accept ? wb_sel_i : r_sel;
  assign w_cur_we  = w_accept ? wb_we_i  : r_we;
  assign w_cur_err = w_accept ? w_adr_err : r_err;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          if (WAIT_CYCLES != 0) begin
            w_state_nxt = ST_WAIT;
            w_cnt_nxt   = WAIT_INIT;
          end else begin
            w_state_nxt = ST_RESP;
          end
        end
      end
      ST_WAIT: begin
        if (!wb_cyc_i) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = 4'd0;
        end else if (r_cnt == 4'd1) begin
          w_state_nxt = ST_RESP;
          w_cnt_nxt   = 4'd0;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      ST_RESP: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  assign w_go_resp   = (w_state_nxt == ST_RESP);
  assign w_wr_en     = rst_i & w_go_resp & w_cur_we & ~w_cur_err;
  assign w_lane_mask = {{8{w_cur_sel[3]}}, {8{w_cur_sel[2]}},
                        {8{w_cur_sel[1]}}, {8{w_cur_sel[0]}}};
  assign w_rd_word   = r_mem[w_cur_idx];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_idx   <= '0;
      r_dat   <= 32'd0;
      r_sel   <= 4'd0;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_idx <= wb_adr_i[DEPTH_LOG2+1:2];
        r_dat <= wb_dat_i;
        r_sel <= wb_sel_i;
        r_we  <= wb_we_i;
        r_err <= w_adr_err;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_ack   <= 1'b0;
      r_dat_o <= 32'd0;
    end else begin
      r_ack   <= w_go_resp & ~w_cur_err;
      r_dat_o <= (w_go_resp & ~w_cur_we & ~w_cur_err) ? (w_rd_word & w_lane_mask) : 32'd0;
    end
  end

`ifdef WB_MEM_ERR_EN
  logic r_err_o;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_err_o <= 1'b0;
    end else begin
      r_err_o <= w_go_resp & w_cur_err;
    end
  end

  assign wb_err_o = r_err_o;
`endif

  // Storage is deliberately outside the reset domain so contents survive reset.
  always_ff @(posedge clk_i) begin
    if (w_wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (w_cur_sel[b]) begin
          r_mem[w_cur_idx][8*b +: 8] <= w_cur_dat[8*b +: 8];
        end
      end
    end
  end

  assign wb_ack_o   = r_ack;
  assign wb_dat_o   = r_dat_o;
  assign wb_stall_o = (r_state != ST_IDLE);

endmodule

// File: tb/tb_wb_mem.sv
// tb_wb_mem: randomized self-checking bench for wb_mem with three wait-state configurations
// (1, 3 and 0) against an array-based memory model.
module tb_wb_mem;

  localparam int NI = 3;
  localparam int DL = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] adr   [NI];
  logic [31:0] dat_i [NI];
  logic [31:0] dat_o [NI];
  logic [3:0]  sel   [NI];
  logic        we    [NI];
  logic        stb   [NI];
  logic        cyc   [NI];
  logic        ack   [NI];
  logic        stall [NI];
`ifdef WB_MEM_ERR_EN
  logic        err   [NI];
`endif

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] mdl     [NI][32];
  logic [31:0] rd_last [NI];
  longint      acc_t   [NI];
  longint      acc_prev[NI];

  always #5 clk = ~clk;

  wb_mem #(.DEPTH_LOG2(DL), .WAIT_CYCLES(1)) u_dut0 (
    .clk_i(clk), .rst_i(rst_n), .wb_adr_i(adr[0]), .wb_dat_i(dat_i[0]), .wb_dat_o(dat_o[0]),
    .wb_sel_i(sel[0]), .wb_we_i(we[0]), .wb_stb_i(stb[0]), .wb_cyc_i(cyc[0]),
    .wb_ack_o(ack[0]), .wb_stall_o(stall[0])
`ifdef WB_MEM_ERR_EN
    , .wb_err_o(err[0])
`endif
  );

  wb_mem #(.DEPTH_LOG2(DL), .WAIT_CYCLES(3)) u_dut1 (
    .clk_i(clk), .rst_i(rst_n), .wb_adr_i(adr[1]), .wb_dat_i(dat_i[1]), .wb_dat_o(dat_o[1]),
    .wb_sel_i(sel[1]), .wb_we_i(we[1]), .wb_stb_i(stb[1]), .wb_cyc_i(cyc[1]),
    .wb_ack_o(ack[1]), .wb_stall_o(stall[1])
`ifdef WB_MEM_ERR_EN
    , .wb_err_o(err[1])
`endif
  );

  wb_mem #(.DEPTH_LOG2(DL), .WAIT_CYCLES(0)) u_dut2 (
    .clk_i(clk), .rst_i(rst_n), .wb_adr_i(adr[2]), .wb_dat_i(dat_i[2]), .wb_dat_o(dat_o[2]),
    .wb_sel_i(sel[2]), .wb_we_i(we[2]), .wb_stb_i(stb[2]), .wb_cyc_i(cyc[2]),
    .wb_ack_o(ack[2]), .wb_stall_o(stall[2])
`ifdef WB_MEM_ERR_EN
    , .wb_err_o(err[2])
`endif
  );

  function automatic int wc(input int k);
    case (k)
      0:       return 1;
      1:       return 3;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] lane_mask(input logic [3:0] s);
    logic [31:0] m;
    m = 32'd0;
    for (int b = 0; b < 4; b++) if (s[b]) m[8*b +: 8] = 8'hFF;
    return m;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic err_of(input int k);
`ifdef WB_MEM_ERR_EN
    return err[k];
`else
    return (k < 0);
`endif
  endfunction

  // One complete transfer on instance k; the model decides data and response type.
  task automatic xfer(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic abort);
    int          n;
    int          stl;
    int          widx;
    logic        got;
    logic        e;
    logic [31:0] m;
    widx = int'((a / 4) % (1 << DL));
    e = 1'b0;
`ifdef WB_MEM_ERR_EN
    e = (a / (1 << (DL + 2))) != 0;
`endif
    chk("stall_idle", 32'(stall[k]), 32'd0);
    adr[k] = a; dat_i[k] = d; sel[k] = s; we[k] = w; cyc[k] = 1'b1; stb[k] = 1'b1;
    @(posedge clk);
    acc_prev[k] = acc_t[k];
    acc_t[k] = $time;
    #1;
    stb[k] = 1'b0;
    if (abort) begin
      cyc[k] = 1'b0;
      got = 1'b0;
      for (int i = 0; i < wc(k) + 3; i++) begin
        if (ack[k] || err_of(k)) got = 1'b1;
        @(posedge clk);
        #1;
      end
      chk("abort_noack", 32'(got), 32'd0);
      return;
    end
    n = 1; stl = 0; got = 1'b0;
    while (n <= 20) begin
      if (stall[k]) stl++;
      if (ack[k] || err_of(k)) begin
        got = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      n++;
    end
    chk("resp_seen", 32'(got), 32'd1);
    if (!got) begin
      cyc[k] = 1'b0;
      return;
    end
    chk("resp_lat", 32'(n), 32'(wc(k) + 1));
    chk("stall_cycles", 32'(stl), 32'(wc(k) + 1));
    chk("ack_flag", 32'(ack[k]), 32'(!e));
`ifdef WB_MEM_ERR_EN
    chk("err_flag", 32'(err[k]), 32'(e));
`endif
    if (!w) begin
      rd_last[k] = dat_o[k];
      chk("rdata", dat_o[k], e ? 32'd0 : (mdl[k][widx] & lane_mask(s)));
    end else if (!e) begin
      m = lane_mask(s);
      mdl[k][widx] = (mdl[k][widx] & ~m) | (d & m);
    end
    @(posedge clk);
    #1;
    cyc[k] = 1'b0;
    chk("ack_drop", 32'(ack[k]), 32'd0);
    chk("dat_idle", dat_o[k], 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          k;
    int          idx;
    logic [31:0] r;
    logic [31:0] a;
    logic [31:0] old;
    logic        ab;

    for (int i = 0; i < NI; i++) begin
      adr[i] = 32'd0; dat_i[i] = 32'd0; sel[i] = 4'd0; we[i] = 1'b0;
      stb[i] = 1'b0; cyc[i] = 1'b0; acc_t[i] = 0; acc_prev[i] = 0; rd_last[i] = 32'd0;
    end
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      chk("rst_ack", 32'(ack[i]), 32'd0);
      chk("rst_stall", 32'(stall[i]), 32'd0);
      chk("rst_dat", dat_o[i], 32'd0);
    end
    #1 rst_n = 1'b1;

    // First request lands on the first rising edge after release.
    for (int i = 0; i < NI; i++) begin
      for (int j = 0; j < 32; j++) xfer(i, 1'b1, 32'(j * 4), $urandom(), 4'hF, 1'b0);
    end

    xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0);
    xfer(0, 1'b0, 32'h10, 32'd0, 4'hF, 1'b0);
    chk("deadbeef", rd_last[0], 32'hDEADBEEF);

    xfer(0, 1'b1, 32'h20, 32'h11223344, 4'hF, 1'b0);
    xfer(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'h5, 1'b0);
    xfer(0, 1'b0, 32'h20, 32'd0, 4'hF, 1'b0);
    chk("lane_merge", rd_last[0], 32'h11BB33DD);
    xfer(0, 1'b1, 32'h20, 32'h99999999, 4'h0, 1'b0);
    xfer(0, 1'b0, 32'h20, 32'd0, 4'hF, 1'b0);
    chk("sel_none", rd_last[0], 32'h11BB33DD);

    old = mdl[1][1];
    xfer(1, 1'b1, 32'h4, 32'h55, 4'hF, 1'b1);
    xfer(1, 1'b0, 32'h4, 32'd0, 4'hF, 1'b0);
    chk("abort_keep", rd_last[1], old);

    // Reset pulse while instance 1 sits in WAIT.
    old = mdl[1][3];
    adr[1] = 32'hC; dat_i[1] = 32'hCAFEF00D; sel[1] = 4'hF; we[1] = 1'b1;
    cyc[1] = 1'b1; stb[1] = 1'b1;
    @(posedge clk);
    #1;
    stb[1] = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rstw_ack", 32'(ack[1]), 32'd0);
    chk("rstw_stall", 32'(stall[1]), 32'd0);
    chk("rstw_dat", dat_o[1], 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc[1] = 1'b0;
    xfer(1, 1'b0, 32'hC, 32'd0, 4'hF, 1'b0);
    chk("rstw_nowrite", rd_last[1], old);

    old = mdl[0][1];
    xfer(0, 1'b1, 32'h1004, 32'h1, 4'hF, 1'b0);
    xfer(0, 1'b0, 32'h4, 32'd0, 4'hF, 1'b0);
`ifdef WB_MEM_ERR_EN
    chk("oob_keep", rd_last[0], old);
`else
    chk("wrap", rd_last[0], 32'h1);
`endif

    for (int i = 0; i < NI; i++) begin
      xfer(i, 1'b0, 32'h8, 32'd0, 4'hF, 1'b0);
      xfer(i, 1'b0, 32'hC, 32'd0, 4'hF, 1'b0);
      chk("b2b_gap", 32'(acc_t[i] - acc_prev[i]), 32'((wc(i) + 2) * 10));
    end

    for (int t = 0; t < 120; t++) begin
      k = int'($urandom_range(0, NI - 1));
      idx = int'($urandom_range(0, 31));
      r = $urandom();
      a = {r[31:12], 5'd0, 5'(idx), r[1:0]};
      ab = (wc(k) > 0) && ($urandom_range(0, 9) == 0);
      xfer(k, 1'($urandom_range(0, 1)), a, $urandom(), 4'($urandom_range(0, 15)), ab);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
